// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: shared constants for the UART RX frame controller.
// Covers the state encoding, error cause codes and the flag bit positions
// of the RX FIFO word {BE,OE,PE,FE,data[7:0]}.
package uart_rx_frame_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LEN     = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_CSUM    = 2'd3;

   localparam logic [2:0] ERR_LINE    = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_CSUM    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   localparam int unsigned FLAG_BE = 11;
   localparam int unsigned FLAG_OE = 10;
   localparam int unsigned FLAG_PE = 9;
   localparam int unsigned FLAG_FE = 8;

   // Line-error flags of one FIFO word; non-zero means the byte is unusable.
   function automatic logic [3:0] word_flags(input logic [11:0] w);
      return {w[FLAG_BE], w[FLAG_OE], w[FLAG_PE], w[FLAG_FE]};
   endfunction

endpackage

// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer: inter-byte timeout counter for the RX frame controller.
// Counts clocks while not cleared; expired is high on the TIMEOUT_CYC-th
// consecutive uncleared clock. The count saturates so it cannot wrap.
module uart_rx_frame_timer
   import uart_rx_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   // Idle-clock counter: cleared by activity, saturating at TIMEOUT_CYC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != CW'(TIMEOUT_CYC)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = !clear && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: drains the UART RX FIFO, parses SOF|LEN|PAYLOAD|CSUM
// frames, streams payload over valid/ready and reports per-frame status.
// Optional feature: define UART_RX_FRAME_TIMEOUT_EN to enable the inter-byte
// timeout (err_code 4); without it the controller waits indefinitely.
module uart_rx_frame_ctrl
   import uart_rx_frame_pkg::*;
#(
   parameter logic [7:0]  SOF_BYTE    = 8'hA5,
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        UART_clk,
   input  logic        rst_n,
   output logic        fifo_rd_en,
   input  logic [11:0] fifo_rd_data,
   input  logic        fifo_empty,
   output logic [7:0]  pl_data,
   output logic        pl_valid,
   input  logic        pl_ready,
   output logic        pl_last,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [2:0]  err_code,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   logic [1:0] state;
   logic       run;
   logic       rd_pend;
   logic [7:0] len_left;
   logic [7:0] csum;
   logic [3:0] flags;
   logic [7:0] rx_byte;
   logic       timeout_hit;
   logic       abort;
   logic [2:0] abort_code;

   assign flags   = word_flags(fifo_rd_data);
   assign rx_byte = fifo_rd_data[7:0];
   assign busy    = (state != ST_IDLE);

   // A pop needs a word, no read in flight, and a free (or freeing) output slot,
   // so the popped byte always finds room when it arrives next cycle.
   assign fifo_rd_en = run && !fifo_empty && !rd_pend && (!pl_valid || pl_ready);

   // Fetch tracking: run holds pops off while in reset, rd_pend marks a word arriving.
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         run     <= 1'b1;
         rd_pend <= fifo_rd_en;
      end
   end

`ifdef UART_RX_FRAME_TIMEOUT_EN
   uart_rx_frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (UART_clk),
      .rst_n   (rst_n),
      .clear   (rd_pend || !busy),
      .expired (timeout_hit)
   );
`else
   // Timeout disabled; TIMEOUT_CYC is kept only so overrides stay legal.
   assign timeout_hit = (TIMEOUT_CYC == 0) && 1'b0;
`endif

   // Abort decode for the word being processed (or an expired timeout).
   always_comb begin
      abort      = 1'b0;
      abort_code = ERR_LINE;
      if (timeout_hit) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
      end else if (rd_pend && (state != ST_IDLE)) begin
         if (flags != '0) begin
            abort      = 1'b1;
            abort_code = ERR_LINE;
         end else begin
            case (state)
               ST_LEN: begin
                  if ((rx_byte == '0) || (rx_byte > MAX_LEN_B)) begin
                     abort      = 1'b1;
                     abort_code = ERR_LEN;
                  end
               end
               ST_CSUM: begin
                  if (rx_byte != csum) begin
                     abort      = 1'b1;
                     abort_code = ERR_CSUM;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Frame FSM, output slot, checksum and status reporting.
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         len_left  <= '0;
         csum      <= '0;
         pl_data   <= '0;
         pl_valid  <= 1'b0;
         pl_last   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
         err_cnt   <= '0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         // A byte already in the slot drains normally even if the frame aborts.
         if (pl_valid && pl_ready) begin
            pl_valid <= 1'b0;
            pl_last  <= 1'b0;
         end
         if (abort) begin
            frame_err <= 1'b1;
            err_code  <= abort_code;
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + 8'd1;
            end
            state <= ST_IDLE;
         end else if (rd_pend) begin
            case (state)
               ST_IDLE: begin
                  if (fifo_rd_data == {4'h0, SOF_BYTE}) begin
                     state <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  len_left <= rx_byte;
                  csum     <= rx_byte;
                  state    <= ST_PAYLOAD;
               end
               ST_PAYLOAD: begin
                  pl_data  <= rx_byte;
                  pl_valid <= 1'b1;
                  pl_last  <= (len_left == 8'd1);
                  csum     <= csum ^ rx_byte;
                  len_left <= len_left - 8'd1;
                  if (len_left == 8'd1) begin
                     state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  frame_ok <= 1'b1;
                  state    <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed bench for uart_rx_frame_ctrl.
// Table of frames with hand-computed payload/status, plus sequences for the
// maximum length, consumer back-pressure, timeout and mid-frame reset.
module tb_uart_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_rd_en;
   logic [11:0] fifo_rd_data = '0;
   logic        fifo_empty;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic        pl_last;
   logic        frame_ok;
   logic        frame_err;
   logic [2:0]  err_code;
   logic [7:0]  err_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int ok_seen = 0;
   int err_seen = 0;

   logic [11:0] fmem [0:255];
   logic [7:0]  wr_ptr = '0;
   logic [7:0]  rd_ptr = '0;
   logic [8:0]  rx_q [$];

   always #5 clk = ~clk;

   uart_rx_frame_ctrl #(
      .SOF_BYTE    (8'hA5),
      .MAX_LEN     (16),
      .TIMEOUT_CYC (16)
   ) dut (
      .UART_clk     (clk),
      .rst_n        (rst_n),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .pl_data      (pl_data),
      .pl_valid     (pl_valid),
      .pl_ready     (pl_ready),
      .pl_last      (pl_last),
      .frame_ok     (frame_ok),
      .frame_err    (frame_err),
      .err_code     (err_code),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   // RX FIFO model: data valid the cycle after the pop.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (wr_ptr == rd_ptr) begin
            errors++;
            $display("FAIL pop_empty actual=1 required=0");
         end
         fifo_rd_data <= fmem[rd_ptr];
         rd_ptr       <= rd_ptr + 8'd1;
      end
   end

   // Consumer/status monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pl_valid && pl_ready) rx_q.push_back({pl_last, pl_data});
         if (frame_ok) ok_seen++;
         if (frame_err) err_seen++;
         if (frame_ok && frame_err) begin
            errors++;
            $display("FAIL ok_err_exclusive actual=11 required=not both");
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [11:0] w);
      fmem[wr_ptr] = w;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0;
      for (int c = 0; c < 400 && quiet < 3; c++) begin
         @(negedge clk);
         if (fifo_empty && !busy && !pl_valid) quiet++;
         else quiet = 0;
      end
      chk({name, "_idle"}, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
   endtask

   typedef struct packed {
      logic [7:0][11:0] w;     // words, first to send at index 7
      int unsigned      nw;
      logic [3:0][7:0]  pl;    // expected payload, first at index 3
      int unsigned      npl;
      logic             last;  // pl_last expected on final payload byte
      int unsigned      nok;
      int unsigned      nerr;
      logic [2:0]       code;
      logic [7:0]       cnt;
   } vec_t;

   localparam int NV = 10;
   vec_t vt [NV];

   initial begin
      int   ok0, er0;
      logic [8:0] got;
      logic [7:0] cs;

      vt[0] = '{w:{12'h0A5,12'h003,12'h011,12'h022,12'h033,12'h003,12'h000,12'h000}, nw:6,
                pl:{8'h11,8'h22,8'h33,8'h00}, npl:3, last:1'b1, nok:1, nerr:0, code:3'd0, cnt:8'd0};
      vt[1] = '{w:{12'h0A5,12'h003,12'h011,12'h022,12'h033,12'h004,12'h000,12'h000}, nw:6,
                pl:{8'h11,8'h22,8'h33,8'h00}, npl:3, last:1'b1, nok:0, nerr:1, code:3'd3, cnt:8'd1};
      vt[2] = '{w:{12'h0A5,12'h000,12'h000,12'h000,12'h000,12'h000,12'h000,12'h000}, nw:2,
                pl:'0, npl:0, last:1'b0, nok:0, nerr:1, code:3'd2, cnt:8'd2};
      vt[3] = '{w:{12'h0A5,12'h011,12'h000,12'h000,12'h000,12'h000,12'h000,12'h000}, nw:2,
                pl:'0, npl:0, last:1'b0, nok:0, nerr:1, code:3'd2, cnt:8'd3};
      vt[4] = '{w:{12'h0A5,12'h002,12'h211,12'h000,12'h000,12'h000,12'h000,12'h000}, nw:3,
                pl:'0, npl:0, last:1'b0, nok:0, nerr:1, code:3'd1, cnt:8'd4};
      vt[5] = '{w:{12'h000,12'h0FF,12'h0A5,12'h002,12'h010,12'h020,12'h032,12'h000}, nw:7,
                pl:{8'h10,8'h20,8'h00,8'h00}, npl:2, last:1'b1, nok:1, nerr:0, code:3'd1, cnt:8'd4};
      vt[6] = '{w:{12'h1A5,12'h0A5,12'h001,12'h07E,12'h07F,12'h000,12'h000,12'h000}, nw:5,
                pl:{8'h7E,8'h00,8'h00,8'h00}, npl:1, last:1'b1, nok:1, nerr:0, code:3'd1, cnt:8'd4};
      vt[7] = '{w:{12'h0A5,12'h403,12'h000,12'h000,12'h000,12'h000,12'h000,12'h000}, nw:2,
                pl:'0, npl:0, last:1'b0, nok:0, nerr:1, code:3'd1, cnt:8'd5};
      vt[8] = '{w:{12'h0A5,12'h001,12'h055,12'h854,12'h000,12'h000,12'h000,12'h000}, nw:4,
                pl:{8'h55,8'h00,8'h00,8'h00}, npl:1, last:1'b1, nok:0, nerr:1, code:3'd1, cnt:8'd6};
      vt[9] = '{w:{12'h0A5,12'h003,12'h0C3,12'h1C4,12'h000,12'h000,12'h000,12'h000}, nw:4,
                pl:{8'hC3,8'h00,8'h00,8'h00}, npl:1, last:1'b0, nok:0, nerr:1, code:3'd1, cnt:8'd7};

      rst_n    = 1'b0;
      pl_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {26'd0, fifo_rd_en, pl_valid, pl_last, frame_ok, frame_err, busy}, 32'd0);
      chk("rst_err_code", {29'd0, err_code}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_pl_data", {24'd0, pl_data}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table-driven frames
      for (int i = 0; i < NV; i++) begin
         rx_q.delete();
         ok0 = ok_seen;
         er0 = err_seen;
         @(posedge clk); #1;
         for (int k = 0; k < int'(vt[i].nw); k++) push(vt[i].w[7-k]);
         wait_idle($sformatf("v%0d", i));
         chk($sformatf("v%0d_npl", i), rx_q.size(), vt[i].npl);
         for (int k = 0; k < int'(vt[i].npl); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 9'h1FF;
            chk($sformatf("v%0d_byte%0d", i, k), {23'd0, got},
                {23'd0, vt[i].last && (k == int'(vt[i].npl) - 1), vt[i].pl[3-k]});
         end
         chk($sformatf("v%0d_ok", i), ok_seen - ok0, vt[i].nok);
         chk($sformatf("v%0d_err", i), err_seen - er0, vt[i].nerr);
         chk($sformatf("v%0d_err_code", i), {29'd0, err_code}, {29'd0, vt[i].code});
         chk($sformatf("v%0d_err_cnt", i), {24'd0, err_cnt}, {24'd0, vt[i].cnt});
      end

      // LEN == MAX_LEN boundary
      rx_q.delete();
      ok0 = ok_seen;
      er0 = err_seen;
      cs  = 8'h10;
      @(posedge clk); #1;
      push(12'h0A5);
      push(12'h010);
      for (int k = 1; k <= 16; k++) begin
         push({4'h0, 8'(k)});
         cs = cs ^ 8'(k);
      end
      push({4'h0, cs});
      wait_idle("maxlen");
      chk("maxlen_npl", rx_q.size(), 32'd16);
      for (int k = 0; k < 16; k++) begin
         got = (k < rx_q.size()) ? rx_q[k] : 9'h1FF;
         chk($sformatf("maxlen_byte%0d", k), {23'd0, got}, {23'd0, (k == 15), 8'(k + 1)});
      end
      chk("maxlen_ok", ok_seen - ok0, 32'd1);
      chk("maxlen_err", err_seen - er0, 32'd0);

      // Back-pressure: consumer stalls with the first payload byte in the slot
      rx_q.delete();
      ok0 = ok_seen;
      @(posedge clk); #1;
      pl_ready = 1'b0;
      push(12'h0A5); push(12'h004); push(12'h001); push(12'h002);
      push(12'h003); push(12'h004); push(12'h000);
      for (int c = 0; c < 50 && !pl_valid; c++) @(negedge clk);
      chk("hold_valid_seen", {31'd0, pl_valid}, 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d", c), {22'd0, pl_valid, fifo_rd_en, pl_data}, {22'd0, 1'b1, 1'b0, 8'h01});
      end
      @(posedge clk); #1;
      pl_ready = 1'b1;
      wait_idle("hold");
      chk("hold_npl", rx_q.size(), 32'd4);
      for (int k = 0; k < 4; k++) begin
         got = (k < rx_q.size()) ? rx_q[k] : 9'h1FF;
         chk($sformatf("hold_byte%0d", k), {23'd0, got}, {23'd0, (k == 3), 8'(k + 1)});
      end
      chk("hold_ok", ok_seen - ok0, 32'd1);

      // Stalled frame: FIFO runs dry mid-payload
      ok0 = ok_seen;
      er0 = err_seen;
      @(posedge clk); #1;
      push(12'h0A5); push(12'h002); push(12'h011);
      repeat (40) @(negedge clk);
`ifdef UART_RX_FRAME_TIMEOUT_EN
      chk("tmo_busy", {31'd0, busy}, 32'd0);
      chk("tmo_err_code", {29'd0, err_code}, 32'd4);
      chk("tmo_err", err_seen - er0, 32'd1);
`else
      chk("tmo_busy", {31'd0, busy}, 32'd1);
      chk("tmo_err", err_seen - er0, 32'd0);
      @(posedge clk); #1;
      push(12'h022); push(12'h031);
      wait_idle("tmo_resume");
      chk("tmo_resume_ok", ok_seen - ok0, 32'd1);
`endif

      // Asynchronous reset mid-frame drops the partial frame silently
      er0 = err_seen;
      @(posedge clk); #1;
      push(12'h0A5); push(12'h003); push(12'h011);
      repeat (10) @(negedge clk);
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", {29'd0, busy, pl_valid, frame_err}, 32'd0);
      chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rx_q.delete();
      ok0 = ok_seen;
      push(12'h022); push(12'h033);
      push(12'h0A5); push(12'h001); push(12'h009); push(12'h008);
      wait_idle("mid");
      chk("mid_err", err_seen - er0, 32'd0);
      chk("mid_ok", ok_seen - ok0, 32'd1);
      chk("mid_npl", rx_q.size(), 32'd1);
      got = (rx_q.size() > 0) ? rx_q[0] : 9'h1FF;
      chk("mid_byte", {23'd0, got}, {23'd0, 1'b1, 8'h09});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
